// File: rtl/hazard_pkg.sv
// Shared opcodes, constants and types for the RV32I hazard controller.
package hazard_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_MA = 2'b01,
    FWD_WB = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       writes_rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       is_load;
    logic       is_mem;
  } fields_t;

endpackage

// File: rtl/hazard_ctrl_inst_fields.sv
// Register-field and operand-usage decode of one RV32I instruction word.
module inst_fields
  import hazard_pkg::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        writes_rd,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        is_load,
  output logic        is_mem
);

  logic [6:0] opcode;
  logic       has_rd;
  logic       unused_bits;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign unused_bits = ^{inst[31:25], inst[14:12]};

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    has_rd   = 1'b0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    is_load  = 1'b0;
    is_mem   = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        has_rd   = 1'b1;
        uses_rs1 = 1'b0;
      end
      OP_JALR, OP_IMM: has_rd = 1'b1;
      OP_LOAD: begin
        has_rd  = 1'b1;
        is_load = 1'b1;
        is_mem  = 1'b1;
      end
      OP_OP: begin
        has_rd   = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: uses_rs2 = 1'b1;
      OP_STORE: begin
        uses_rs2 = 1'b1;
        is_mem   = 1'b1;
      end
      default: ;
    endcase
  end

  assign writes_rd = has_rd && (rd != 5'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding, load-use stall, branch flush and data-memory freeze control
// for the 5-stage RV32I pipeline, with a sticky memory-wait watchdog.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst_Id,
  input  logic [31:0]      inst_Ex,
  input  logic [31:0]      inst_Ma,
  input  logic [31:0]      inst_Wb,
  input  logic             pc_sel,
  input  logic             dmem_ready,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  localparam int S_ID = 0;
  localparam int S_EX = 1;
  localparam int S_MA = 2;
  localparam int S_WB = 3;

  logic [31:0] insts [4];
  fields_t     f     [4];

  assign insts[S_ID] = inst_Id;
  assign insts[S_EX] = inst_Ex;
  assign insts[S_MA] = inst_Ma;
  assign insts[S_WB] = inst_Wb;

  for (genvar s = 0; s < 4; s++) begin : g_dec
    inst_fields u_fields (
      .inst      (insts[s]),
      .rd        (f[s].rd),
      .rs1       (f[s].rs1),
      .rs2       (f[s].rs2),
      .writes_rd (f[s].writes_rd),
      .uses_rs1  (f[s].uses_rs1),
      .uses_rs2  (f[s].uses_rs2),
      .is_load   (f[s].is_load),
      .is_mem    (f[s].is_mem)
    );
  end

  // Not every decoded field is needed in every stage.
  logic unused_fields;
  assign unused_fields = ^{f[S_ID], f[S_EX], f[S_MA], f[S_WB]};

  // MA holds the younger result, so it wins over WB; writes_rd already excludes x0.
  function automatic fwd_sel_e pick_src(input logic [4:0] rs, input fields_t ma, input fields_t wb);
    if (ma.writes_rd && ma.rd == rs) return FWD_MA;
    if (wb.writes_rd && wb.rd == rs) return FWD_WB;
    return FWD_RF;
  endfunction

  fwd_sel_e fwd_a, fwd_b;
  logic     load_use, mem_busy, active;

  assign fwd_a = pick_src(f[S_EX].rs1, f[S_MA], f[S_WB]);
  assign fwd_b = pick_src(f[S_EX].rs2, f[S_MA], f[S_WB]);

  assign load_use = f[S_EX].is_load && f[S_EX].writes_rd &&
                    ((f[S_ID].uses_rs1 && f[S_ID].rs1 == f[S_EX].rd) ||
                     (f[S_ID].uses_rs2 && f[S_ID].rs2 == f[S_EX].rd));

  assign mem_busy = f[S_MA].is_mem && !dmem_ready;

  // Reset level gates every control output so the pipeline is quiet while reset is low.
  assign active = reset && !mem_busy;

  assign fwd_a_sel = reset ? fwd_a : FWD_RF;
  assign fwd_b_sel = reset ? fwd_b : FWD_RF;
  assign freeze    = reset && mem_busy;
  assign flush_id  = active && pc_sel;
  assign bubble_ex = active && (pc_sel || load_use);
  assign stall_if  = active && !pc_sel && load_use;
  assign stall_id  = stall_if;

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_MAX - WAIT_W'(1)) mem_timeout <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((stall_if || freeze) && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_id && flush_cnt != '1)             flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
